// File: rtl/serial_tile_rx.sv
// serial_tile_rx
//   Serial-to-parallel receiver for systolic-array operand tiles.
//   LANES serial lanes share one bit strobe (ser_en) and one frame sync
//   (ser_fsync). Each frame carries ELEMS words of W bits per lane. Assembled
//   words are queued in a DEPTH-entry FIFO and leave on a valid/ready port
//   with an end-of-tile marker.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   ser_en     in   bit strobe; ser_fsync/ser_data sampled only when 1
//   ser_fsync  in   frame sync, one strobed bit-time, carries no data
//   ser_data   in   serial data, lane i on bit i
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head when out_valid & out_ready
//   out_data   out  lane i word at [i*W +: W]
//   out_last   out  head is element ELEMS-1 of its frame
//   frame_err  out  one-cycle pulse: sync inside an unfinished frame
//   overflow   out  sticky: word dropped because FIFO was full
//   frame_cnt  out  completed frames, wraps at 2^16
module serial_tile_rx #(
    parameter int W         = 8,
    parameter int LANES     = 1,
    parameter int ELEMS     = 16,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_en,
    input  logic                 ser_fsync,
    input  logic [LANES-1:0]     ser_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic                 out_last,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [15:0]          frame_cnt
);

    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam int ECW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int DW  = LANES * W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ECW-1:0]   elem_cnt_q, elem_cnt_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DW:0]      mem_q [DEPTH];

    logic [DW-1:0]    shifted_s;
    logic             push_s;
    logic             push_last_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             wr_en_s;
    logic [DW:0]      head_s;

    // Per-lane shift of the incoming bit into the word under assembly.
    always_comb begin
        shifted_s = shreg_q;
        for (int l = 0; l < LANES; l++) begin
            if (MSB_FIRST != 0) begin
                shifted_s[l*W +: W] = {shreg_q[l*W +: W-1], ser_data[l]};
            end else begin
                shifted_s[l*W +: W] = {ser_data[l], shreg_q[l*W+1 +: W-1]};
            end
        end
    end

    // Framing FSM: next state, counters, push request.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        elem_cnt_d  = elem_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        if (ser_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (ser_fsync) begin
                        state_d    = ST_SHIFT;
                        bit_cnt_d  = {BCW{1'b0}};
                        elem_cnt_d = {ECW{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ser_fsync) begin
                        // Sync inside a frame: drop the partial word, restart.
                        frame_err_d = 1'b1;
                        bit_cnt_d   = {BCW{1'b0}};
                        elem_cnt_d  = {ECW{1'b0}};
                    end else begin
                        shreg_d = shifted_s;
                        if (bit_cnt_q == BCW'(W - 1)) begin
                            push_s    = 1'b1;
                            bit_cnt_d = {BCW{1'b0}};
                            if (elem_cnt_q == ECW'(ELEMS - 1)) begin
                                push_last_s = 1'b1;
                                elem_cnt_d  = {ECW{1'b0}};
                                frame_cnt_d = frame_cnt_q + 16'd1;
                                state_d     = ST_IDLE;
                            end else begin
                                elem_cnt_d = elem_cnt_q + {{(ECW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO control: a pop frees the head slot on the same edge, so a push
    // into a full FIFO is accepted whenever the head is leaving.
    always_comb begin
        empty_s    = (wr_ptr_q == rd_ptr_q);
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s      = !empty_s && out_ready;
        wr_en_s    = push_s && (!full_s || pop_s);
        overflow_d = overflow_q || (push_s && full_s && !pop_s);
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State, counters and FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {BCW{1'b0}};
            elem_cnt_q  <= {ECW{1'b0}};
            shreg_q     <= {DW{1'b0}};
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(DW+1){1'b0}};
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            elem_cnt_q  <= elem_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {push_last_s, shifted_s};
            end
        end
    end

    // Outputs come straight from flops; the head stays put while stalled.
    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty_s;
    assign out_data  = head_s[DW-1:0];
    assign out_last  = head_s[DW];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_tile_rx.sv
// tb_serial_tile_rx
//   Directed bench for serial_tile_rx. Four instances share the serial
//   stimulus: A (W8,ELEMS4,LSB), B (MSB-first,ELEMS1), C (ELEMS6),
//   D (LANES2,ELEMS2). Each has its own out_ready; every accepted word is
//   logged as {id,last,data} and compared against hand-computed values.
module tb_serial_tile_rx;

    logic        clk;
    logic        rst_n;
    logic        ser_en;
    logic        ser_fsync;
    logic [1:0]  ser_data;
    logic [3:0]  rdy;
    int          gap;
    int          n_chk;
    int          n_fail;

    logic        a_valid, a_last, a_ferr, a_ovf;
    logic [7:0]  a_data;
    logic [15:0] a_fcnt;
    logic        b_valid, b_last, b_ferr, b_ovf;
    logic [7:0]  b_data;
    logic [15:0] b_fcnt;
    logic        c_valid, c_last, c_ferr, c_ovf;
    logic [7:0]  c_data;
    logic [15:0] c_fcnt;
    logic        d_valid, d_last, d_ferr, d_ovf;
    logic [15:0] d_data;
    logic [15:0] d_fcnt;

    logic [18:0] mq[$];

    serial_tile_rx #(.W(8), .LANES(1), .ELEMS(4), .DEPTH(4), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_fsync(ser_fsync),
        .ser_data(ser_data[0]), .out_valid(a_valid), .out_ready(rdy[0]),
        .out_data(a_data), .out_last(a_last), .frame_err(a_ferr),
        .overflow(a_ovf), .frame_cnt(a_fcnt));

    serial_tile_rx #(.W(8), .LANES(1), .ELEMS(1), .DEPTH(4), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_fsync(ser_fsync),
        .ser_data(ser_data[0]), .out_valid(b_valid), .out_ready(rdy[1]),
        .out_data(b_data), .out_last(b_last), .frame_err(b_ferr),
        .overflow(b_ovf), .frame_cnt(b_fcnt));

    serial_tile_rx #(.W(8), .LANES(1), .ELEMS(6), .DEPTH(4), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_fsync(ser_fsync),
        .ser_data(ser_data[0]), .out_valid(c_valid), .out_ready(rdy[2]),
        .out_data(c_data), .out_last(c_last), .frame_err(c_ferr),
        .overflow(c_ovf), .frame_cnt(c_fcnt));

    serial_tile_rx #(.W(8), .LANES(2), .ELEMS(2), .DEPTH(4), .MSB_FIRST(0)) u_d (
        .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_fsync(ser_fsync),
        .ser_data(ser_data), .out_valid(d_valid), .out_ready(rdy[3]),
        .out_data(d_data), .out_last(d_last), .frame_err(d_ferr),
        .overflow(d_ovf), .frame_cnt(d_fcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every handshake, sampled mid-cycle, as {id, last, data}.
    always @(negedge clk) begin
        if (a_valid === 1'b1 && rdy[0] === 1'b1) mq.push_back({2'd0, a_last, 8'h00, a_data});
        if (b_valid === 1'b1 && rdy[1] === 1'b1) mq.push_back({2'd1, b_last, 8'h00, b_data});
        if (c_valid === 1'b1 && rdy[2] === 1'b1) mq.push_back({2'd2, c_last, 8'h00, c_data});
        if (d_valid === 1'b1 && rdy[3] === 1'b1) mq.push_back({2'd3, d_last, d_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expw(input string tag, input logic [1:0] id, input logic last, input logic [15:0] d);
        logic [18:0] got;
        got = (mq.size() > 0) ? mq.pop_front() : 19'h7FFFF;
        chk(tag, {13'd0, got}, {13'd0, id, last, d});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ser_en    = 1'b0;
        ser_fsync = 1'b0;
        ser_data  = 2'b00;
        rdy       = 4'b0000;
        gap       = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic sbit(input logic fs, input logic [1:0] d);
        ser_en    = 1'b1;
        ser_fsync = fs;
        ser_data  = d;
        @(posedge clk);
        #1;
        ser_en    = 1'b0;
        ser_fsync = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One element per lane, LSB first.
    task automatic sword(input logic [7:0] w0, input logic [7:0] w1);
        for (int i = 0; i < 8; i++) sbit(1'b0, {w1[i], w0[i]});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        n_chk  = 0;
        n_fail = 0;
        do_reset();

        // Reset state
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_data", {24'd0, a_data}, 32'd0);
        chk("rst_last", {31'd0, a_last}, 32'd0);
        chk("rst_ferr", {31'd0, a_ferr}, 32'd0);
        chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
        chk("rst_fcnt", {16'd0, a_fcnt}, 32'd0);
        chk("rst_d_data", {16'd0, d_data}, 32'd0);

        // 1) LSB-first frame {1,2,3,-4}, consumer always ready
        rdy[0] = 1'b1;
        sbit(1'b1, 2'b00);
        sword(8'h01, 8'h00); sword(8'h02, 8'h00);
        sword(8'h03, 8'h00); sword(8'hFC, 8'h00);
        idle(4);
        expw("t1_w0", 2'd0, 1'b0, 16'h0001);
        expw("t1_w1", 2'd0, 1'b0, 16'h0002);
        expw("t1_w2", 2'd0, 1'b0, 16'h0003);
        expw("t1_w3", 2'd0, 1'b1, 16'h00FC);
        chk("t1_count", mq.size(), 32'd0);
        chk("t1_fcnt", {16'd0, a_fcnt}, 32'd1);
        chk("t1_ovf", {31'd0, a_ovf}, 32'd0);

        // 2) MSB-first single-element frame, bits 1,0,1,0,0,1,0,1
        do_reset();
        w = 8'hA5;
        sbit(1'b1, 2'b00);
        for (int i = 7; i > 0; i--) sbit(1'b0, {1'b0, w[i]});
        chk("t2_valid_pre", {31'd0, b_valid}, 32'd0);
        sbit(1'b0, {1'b0, w[0]});
        chk("t2_valid_post", {31'd0, b_valid}, 32'd1);
        chk("t2_data", {24'd0, b_data}, 32'h0000_00A5);
        chk("t2_last", {31'd0, b_last}, 32'd1);
        chk("t2_fcnt", {16'd0, b_fcnt}, 32'd1);

        // 3) ELEMS=6 into DEPTH=4 with consumer stalled
        do_reset();
        sbit(1'b1, 2'b00);
        for (int e = 0; e < 6; e++) sword(8'h10 + 8'(e), 8'h00);
        chk("t3_ovf", {31'd0, c_ovf}, 32'd1);
        chk("t3_valid", {31'd0, c_valid}, 32'd1);
        chk("t3_head", {24'd0, c_data}, 32'h0000_0010);
        idle(3);
        chk("t3_head_hold", {24'd0, c_data}, 32'h0000_0010);
        chk("t3_fcnt", {16'd0, c_fcnt}, 32'd1);
        rdy[2] = 1'b1;
        idle(8);
        for (int e = 0; e < 4; e++) expw("t3_pop", 2'd2, 1'b0, 16'h0010 + 16'(e));
        chk("t3_count", mq.size(), 32'd0);
        chk("t3_empty", {31'd0, c_valid}, 32'd0);
        chk("t3_ovf_sticky", {31'd0, c_ovf}, 32'd1);

        // 4) Sync, 3 bits, sync again, then a clean frame {7,8,9,10}
        do_reset();
        rdy[0] = 1'b1;
        sbit(1'b1, 2'b00);
        sbit(1'b0, 2'b01); sbit(1'b0, 2'b01); sbit(1'b0, 2'b01);
        sbit(1'b1, 2'b00);
        chk("t4_ferr_pulse", {31'd0, a_ferr}, 32'd1);
        idle(1);
        chk("t4_ferr_clear", {31'd0, a_ferr}, 32'd0);
        sword(8'd7, 8'h00); sword(8'd8, 8'h00);
        sword(8'd9, 8'h00); sword(8'd10, 8'h00);
        idle(4);
        expw("t4_w0", 2'd0, 1'b0, 16'd7);
        expw("t4_w1", 2'd0, 1'b0, 16'd8);
        expw("t4_w2", 2'd0, 1'b0, 16'd9);
        expw("t4_w3", 2'd0, 1'b1, 16'd10);
        chk("t4_count", mq.size(), 32'd0);
        chk("t4_fcnt", {16'd0, a_fcnt}, 32'd1);

        // 5) Two lanes, then the same frame with a strobe every 3rd clock
        for (int g = 0; g < 2; g++) begin
            do_reset();
            gap = 2 * g;
            rdy[3] = 1'b1;
            sbit(1'b1, 2'b00);
            sword(8'h01, 8'hFF);
            sword(8'h02, 8'h05);
            idle(4);
            expw("t5_w0", 2'd3, 1'b0, 16'hFF01);
            expw("t5_w1", 2'd3, 1'b1, 16'h0502);
            chk("t5_count", mq.size(), 32'd0);
            chk("t5_fcnt", {16'd0, d_fcnt}, 32'd1);
        end

        // Full FIFO with push and pop on the same edge
        do_reset();
        sbit(1'b1, 2'b00);
        sword(8'h11, 8'h00); sword(8'h22, 8'h00);
        sword(8'h33, 8'h00); sword(8'h44, 8'h00);
        chk("fp_ovf_pre", {31'd0, a_ovf}, 32'd0);
        w = 8'h55;
        sbit(1'b1, 2'b00);
        for (int i = 0; i < 7; i++) sbit(1'b0, {1'b0, w[i]});
        rdy[0] = 1'b1;
        sbit(1'b0, {1'b0, w[7]});
        rdy[0] = 1'b0;
        chk("fp_ovf", {31'd0, a_ovf}, 32'd0);
        chk("fp_head", {24'd0, a_data}, 32'h0000_0022);
        rdy[0] = 1'b1;
        sword(8'h66, 8'h00); sword(8'h77, 8'h00); sword(8'h88, 8'h00);
        idle(8);
        expw("fp_w0", 2'd0, 1'b0, 16'h0011);
        expw("fp_w1", 2'd0, 1'b0, 16'h0022);
        expw("fp_w2", 2'd0, 1'b0, 16'h0033);
        expw("fp_w3", 2'd0, 1'b1, 16'h0044);
        expw("fp_w4", 2'd0, 1'b0, 16'h0055);
        expw("fp_w5", 2'd0, 1'b0, 16'h0066);
        expw("fp_w6", 2'd0, 1'b0, 16'h0077);
        expw("fp_w7", 2'd0, 1'b1, 16'h0088);
        chk("fp_count", mq.size(), 32'd0);
        chk("fp_fcnt", {16'd0, a_fcnt}, 32'd2);
        chk("fp_ovf_end", {31'd0, a_ovf}, 32'd0);

        // 6) One-clock reset mid-frame with two words queued
        do_reset();
        sbit(1'b1, 2'b00);
        sword(8'h31, 8'h00); sword(8'h32, 8'h00);
        sbit(1'b0, 2'b01); sbit(1'b0, 2'b00); sbit(1'b0, 2'b01);
        chk("t6_valid_pre", {31'd0, a_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_valid_rst", {31'd0, a_valid}, 32'd0);
        chk("t6_fcnt_rst", {16'd0, a_fcnt}, 32'd0);
        rdy[0] = 1'b1;
        sbit(1'b1, 2'b00);
        sword(8'h41, 8'h00); sword(8'h42, 8'h00);
        sword(8'h43, 8'h00); sword(8'h44, 8'h00);
        idle(4);
        expw("t6_w0", 2'd0, 1'b0, 16'h0041);
        expw("t6_w1", 2'd0, 1'b0, 16'h0042);
        expw("t6_w2", 2'd0, 1'b0, 16'h0043);
        expw("t6_w3", 2'd0, 1'b1, 16'h0044);
        chk("t6_count", mq.size(), 32'd0);
        chk("t6_fcnt", {16'd0, a_fcnt}, 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
